// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// stream_mux_pkg : shared constants for the stream_mux_rr block.
// Rev 1.0
// ============================================================================
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational rotating-priority search starting at rr_ptr.
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    int               pos;
    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        pos         = 0;
        idx         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = int'(rr_ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = SEL_W'(pos);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// stream_mux_rr : N-channel stream mux with one registered output stage,
// fixed-select or round-robin. STREAM_MUX_RR_CNT_EN adds per-channel counters.
// Rev 1.0
// ============================================================================
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
`ifdef STREAM_MUX_RR_CNT_EN
    input  logic               clr_cnt,
    output logic [N*CNT_W-1:0] beat_cnt,
`endif
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    input  logic               out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             load_ok;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             arb_valid;
    logic [SEL_W-1:0] arb_idx;
    logic             xfer;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    always_comb begin
        load_ok = !out_valid_q || out_ready;

        if (mode == MODE_RR) begin
            grant_valid = arb_valid;
            grant_idx   = arb_idx;
        end else begin
            grant_valid = (int'(sel) < N);
            grant_idx   = sel;
        end

        // Ready is forced low while reset is held, since load_ok alone would be 1.
        in_ready = '0;
        if (sys_rst_n && load_ok && grant_valid) begin
            in_ready[grant_idx] = 1'b1;
        end
        xfer = |(in_valid & in_ready);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_ch_d    = grant_idx;
            if (mode == MODE_RR) begin
                rr_ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef STREAM_MUX_RR_CNT_EN
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    // Clear has priority over a same-cycle increment.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_cnt) begin
                cnt_d[k] = '0;
            end else if (in_valid[k] && in_ready[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_beat_cnt
            assign beat_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    endgenerate
`endif

endmodule
`default_nettype wire
